// File: rtl/ix32_encoder.sv
// RV32IM instruction encoder: packs decoded fields into R/I/S/B/U/J words, flags
// illegal requests, and delivers beats through an output register plus skid buffer.
module ix32_encoder #(
  parameter int ERRW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [31:0]     in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_insn,
  output logic            out_err,
  output logic [ERRW-1:0] err_count
);

  localparam logic [4:0] OPC_LOAD      = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM  = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
  localparam logic [4:0] OPC_AUIPC     = 5'b00101;
  localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
  localparam logic [4:0] OPC_STORE     = 5'b01000;
  localparam logic [4:0] OPC_OP        = 5'b01100;
  localparam logic [4:0] OPC_LUI       = 5'b01101;
  localparam logic [4:0] OPC_OP_32     = 5'b01110;
  localparam logic [4:0] OPC_BRANCH    = 5'b11000;
  localparam logic [4:0] OPC_JALR      = 5'b11001;
  localparam logic [4:0] OPC_JAL       = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_e;

  fmt_e        fmt;
  logic [6:0]  opc;
  logic        is_shift;
  logic        imm12_bad;
  logic        imm13_bad;
  logic        imm21_bad;
  logic [31:0] raw;
  logic        enc_err;
  logic [31:0] enc_insn;
  logic        skid_valid;
  logic        skid_err;
  logic [31:0] skid_insn;
  logic        in_fire;

  assign opc      = {in_op, 2'b11};
  assign is_shift = (in_op == OPC_OP_IMM) && (in_funct3 == 3'b001 || in_funct3 == 3'b101);

  // Range checks are "upper bits are a sign extension", plus evenness for B/J.
  assign imm12_bad = in_imm[31:11] != {21{in_imm[11]}};
  assign imm13_bad = in_imm[0] | (in_imm[31:12] != {20{in_imm[12]}});
  assign imm21_bad = in_imm[0] | (in_imm[31:20] != {12{in_imm[20]}});

  always_comb begin
    fmt = FMT_BAD;
    case (in_op)
      OPC_OP, OPC_OP_32:                               fmt = FMT_R;
      OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD, OPC_JALR,
      OPC_MISC_MEM, OPC_SYSTEM:                        fmt = FMT_I;
      OPC_STORE:                                       fmt = FMT_S;
      OPC_BRANCH:                                      fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                              fmt = FMT_U;
      OPC_JAL:                                         fmt = FMT_J;
      default:                                         fmt = FMT_BAD;
    endcase
  end

  always_comb begin
    raw     = '0;
    enc_err = 1'b0;
    case (fmt)
      FMT_R: begin
        raw = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, opc};
        if (in_op == OPC_OP)
          enc_err = !(in_funct7 inside {7'b0000000, 7'b0100000, 7'b0000001}) ||
                    (in_funct7 == 7'b0100000 && !(in_funct3 inside {3'b000, 3'b101}));
      end
      FMT_I: begin
        if (is_shift) begin
          raw     = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, opc};
          enc_err = (in_imm[31:5] != '0) ||
                    !(in_funct7 inside {7'b0000000, 7'b0100000}) ||
                    (in_funct7 == 7'b0100000 && in_funct3 == 3'b001);
        end else begin
          raw     = {in_imm[11:0], in_rs1, in_funct3, in_rd, opc};
          enc_err = imm12_bad;
        end
        if (in_op == OPC_LOAD && !(in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
          enc_err = 1'b1;
        if (in_op == OPC_JALR && in_funct3 != 3'b000)
          enc_err = 1'b1;
      end
      FMT_S: begin
        raw     = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], opc};
        enc_err = imm12_bad || (in_funct3 > 3'b010);
      end
      FMT_B: begin
        raw     = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], opc};
        enc_err = imm13_bad || (in_funct3 inside {3'b010, 3'b011});
      end
      FMT_U: begin
        raw     = {in_imm[31:12], in_rd, opc};
        enc_err = in_imm[11:0] != '0;
      end
      FMT_J: begin
        raw     = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
        enc_err = imm21_bad;
      end
      default: enc_err = 1'b1;
    endcase
    enc_insn = enc_err ? '0 : raw;
  end

  assign in_ready = !skid_valid;
  assign in_fire  = in_valid & in_ready;

  // The skid only fills while the output register is stalled, so whenever the
  // skid holds a beat the output register is valid too.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_insn   <= '0;
      out_err    <= 1'b0;
      skid_valid <= 1'b0;
      skid_insn  <= '0;
      skid_err   <= 1'b0;
    end else if (skid_valid) begin
      if (out_ready) begin
        out_insn   <= skid_insn;
        out_err    <= skid_err;
        skid_valid <= 1'b0;
      end
    end else if (in_fire) begin
      if (!out_valid || out_ready) begin
        out_valid <= 1'b1;
        out_insn  <= enc_insn;
        out_err   <= enc_err;
      end else begin
        skid_valid <= 1'b1;
        skid_insn  <= enc_insn;
        skid_err   <= enc_err;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      err_count <= '0;
    else if (in_fire && enc_err && err_count != '1)
      err_count <= err_count + ERRW'(1);
  end

endmodule

// File: tb/tb_ix32_encoder.sv
// Self-checking bench for ix32_encoder: directed ISA examples, backpressure and
// reset cases, then randomized traffic scored against an arithmetic reference model.
module tb_ix32_encoder;

  localparam int ERRW = 3;

  localparam logic [4:0] LOAD = 5'b00000, MISC_MEM = 5'b00011, OP_IMM = 5'b00100,
                         AUIPC = 5'b00101, OP_IMM_32 = 5'b00110, STORE = 5'b01000,
                         OP = 5'b01100, LUI = 5'b01101, OP_32 = 5'b01110,
                         OP_FP = 5'b10100, BRANCH = 5'b11000, JALR = 5'b11001,
                         JAL = 5'b11011, SYSTEM = 5'b11100;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [4:0]      in_op = '0;
  logic [2:0]      in_funct3 = '0;
  logic [6:0]      in_funct7 = '0;
  logic [4:0]      in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0]     in_imm = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [31:0]     out_insn;
  logic            out_err;
  logic [ERRW-1:0] err_count;

  int total_checks = 0;
  int bad_checks = 0;

  ix32_encoder #(.ERRW(ERRW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
    .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference model: returns {err, insn}, built from the ISA field rules with plain arithmetic.
  function automatic logic [32:0] model(input logic [4:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [31:0] imm);
    int s;
    bit err;
    logic [31:0] w, opc_f, rd_f, f3_f, rs1_f, rs2_f, f7_f;
    s = $signed(imm);
    err = 0;
    w = 0;
    opc_f = {25'd0, op, 2'b11};
    rd_f  = 32'(rd) << 7;
    f3_f  = 32'(f3) << 12;
    rs1_f = 32'(rs1) << 15;
    rs2_f = 32'(rs2) << 20;
    f7_f  = 32'(f7) << 25;
    if (op == OP || op == OP_32) begin
      w = f7_f | rs2_f | rs1_f | f3_f | rd_f | opc_f;
      if (op == OP)
        err = !(f7 == 7'h00 || f7 == 7'h20 || f7 == 7'h01) || (f7 == 7'h20 && f3 != 0 && f3 != 5);
    end else if (op inside {OP_IMM, OP_IMM_32, LOAD, JALR, MISC_MEM, SYSTEM}) begin
      if (op == OP_IMM && (f3 == 1 || f3 == 5)) begin
        w = f7_f | ((imm & 31) << 20) | rs1_f | f3_f | rd_f | opc_f;
        err = s < 0 || s > 31 || !(f7 == 7'h00 || f7 == 7'h20) || (f7 == 7'h20 && f3 == 1);
      end else begin
        w = ((imm & 32'hFFF) << 20) | rs1_f | f3_f | rd_f | opc_f;
        err = s < -2048 || s > 2047;
        if (op == LOAD && !(f3 inside {0, 1, 2, 4, 5})) err = 1;
        if (op == JALR && f3 != 0) err = 1;
      end
    end else if (op == STORE) begin
      w = (((imm >> 5) & 32'h7F) << 25) | rs2_f | rs1_f | f3_f | ((imm & 31) << 7) | opc_f;
      err = s < -2048 || s > 2047 || f3 > 2;
    end else if (op == BRANCH) begin
      w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | rs2_f | rs1_f | f3_f |
          (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | opc_f;
      err = (s % 2 != 0) || s < -4096 || s > 4094 || f3 == 2 || f3 == 3;
    end else if (op == LUI || op == AUIPC) begin
      w = (imm & 32'hFFFFF000) | rd_f | opc_f;
      err = (imm & 32'hFFF) != 0;
    end else if (op == JAL) begin
      w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 1) << 20) |
          (imm & 32'hFF000) | rd_f | opc_f;
      err = (s % 2 != 0) || s < -(1 << 20) || s > (1 << 20) - 1;
    end else begin
      err = 1;
    end
    if (err) w = 0;
    return {err, w};
  endfunction

  task automatic setRequest(input logic [4:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] imm);
    in_op = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Sends one request with the consumer ready and checks the beat one cycle after accept.
  task automatic applyStimulus(input string tag, input logic [4:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm,
                               input logic [31:0] exp_insn, input logic exp_err);
    int waited;
    @(negedge clk);
    out_ready = 1'b1;
    setRequest(op, f3, f7, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) checkOutput({tag, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_insn"}, out_insn, exp_insn);
    checkOutput({tag, "_err"}, 32'(out_err), 32'(exp_err));
  endtask

  function automatic logic [31:0] randImm();
    logic [31:0] r;
    logic [31:0] edges [12];
    edges = '{32'd2047, 32'hFFFFF800, 32'd2048, 32'hFFFFF7FF, 32'd4094, 32'hFFFFF000,
              32'd4096, 32'd31, 32'd32, 32'h000FFFFE, 32'hFFF00000, 32'h00100000};
    case ($urandom_range(0, 5))
      0: r = 32'($urandom_range(0, 4200)) - 32'd2100;
      1: r = $urandom();
      2: r = 32'($urandom_range(0, 40));
      3: r = edges[$urandom_range(0, 11)];
      4: r = $urandom() & 32'hFFFFF000;
      default: r = (32'($urandom_range(0, 1 << 21)) - 32'(1 << 20)) & 32'hFFFFFFFE;
    endcase
    return r;
  endfunction

  logic [32:0] exp_q[$];
  logic [32:0] head;
  logic [32:0] exp_m;
  logic [31:0] held_insn;
  logic        held_err;
  logic        was_stalled;
  int          err_exp;
  logic [4:0]  legal_ops [13];

  initial begin
    legal_ops = '{LOAD, MISC_MEM, OP_IMM, AUIPC, OP_IMM_32, STORE, OP, LUI, OP_32,
                  BRANCH, JALR, JAL, SYSTEM};

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_err", 32'(out_err), 32'd0);
    checkOutput("rst_out_insn", out_insn, 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;

    // Directed ISA examples
    applyStimulus("addi", OP_IMM, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0);
    applyStimulus("srai", OP_IMM, 3'b101, 7'h20, 5'd5, 5'd6, 5'd0, 32'd3, 32'h40335293, 1'b0);
    applyStimulus("beq", BRANCH, 3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8, 32'hFE208CE3, 1'b0);
    applyStimulus("jal", JAL, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h001000EF, 1'b0);
    applyStimulus("lui", LUI, 3'b000, 7'h00, 5'd10, 5'd0, 5'd0, 32'h12345000, 32'h12345537, 1'b0);
    applyStimulus("lui_bad", LUI, 3'b000, 7'h00, 5'd10, 5'd0, 5'd0, 32'h12345001, 32'd0, 1'b1);
    checkOutput("lui_bad_count", 32'(err_count), 32'd1);

    pulseReset();
    applyStimulus("br_odd", BRANCH, 3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3, 32'd0, 1'b1);
    applyStimulus("ld_f3", LOAD, 3'b011, 7'h00, 5'd1, 5'd2, 5'd0, 32'd0, 32'd0, 1'b1);
    applyStimulus("st_rng", STORE, 3'b010, 7'h00, 5'd0, 5'd1, 5'd2, 32'd2048, 32'd0, 1'b1);
    applyStimulus("op_fp", OP_FP, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 1'b1);
    checkOutput("four_err_count", 32'(err_count), 32'd4);

    // Backpressure through the skid buffer
    @(negedge clk);
    out_ready = 1'b0;
    setRequest(OP_IMM, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput("bp_a_out", out_insn, 32'h00500093);
    setRequest(OP_IMM, 3'b101, 7'h20, 5'd5, 5'd6, 5'd0, 32'd3);
    @(negedge clk);
    checkOutput("bp_ready_low", 32'(in_ready), 32'd0);
    checkOutput("bp_a_hold1", out_insn, 32'h00500093);
    setRequest(JAL, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048);
    @(negedge clk);
    checkOutput("bp_ready_low2", 32'(in_ready), 32'd0);
    checkOutput("bp_a_hold2", out_insn, 32'h00500093);
    checkOutput("bp_a_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_b_out", out_insn, 32'h40335293);
    checkOutput("bp_ready_high", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp_c_out", out_insn, 32'h001000EF);
    checkOutput("bp_c_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    checkOutput("bp_drained", 32'(out_valid), 32'd0);

    // Reset with both registers full; handshakes during reset are discarded
    out_ready = 1'b0;
    setRequest(OP_FP, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0);
    in_valid = 1'b1;
    @(negedge clk);
    setRequest(OP_IMM, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    @(negedge clk);
    checkOutput("full_ready_low", 32'(in_ready), 32'd0);
    checkOutput("full_err_count", 32'(err_count), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstfull_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rstfull_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rstfull_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_discard_valid", 32'(out_valid), 32'd0);

    // Randomized traffic against the reference model
    err_exp = 0;
    was_stalled = 1'b0;
    held_insn = '0;
    held_err = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      checkOutput("rand_err_count", 32'(err_count), 32'(err_exp));
      if (was_stalled) begin
        checkOutput("rand_hold_valid", 32'(out_valid), 32'd1);
        checkOutput("rand_hold_insn", out_insn, held_insn);
        checkOutput("rand_hold_err", 32'(out_err), 32'(held_err));
      end
      setRequest(($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31)) : legal_ops[$urandom_range(0, 12)],
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) :
                   (($urandom_range(0, 2) == 0) ? 7'h01 : (($urandom_range(0, 1) == 0) ? 7'h20 : 7'h00)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 randImm());
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("rand_unexpected_beat", 32'd1, 32'd0);
        end else begin
          head = exp_q.pop_front();
          checkOutput("rand_insn", out_insn, head[31:0]);
          checkOutput("rand_err", 32'(out_err), 32'(head[32]));
        end
      end
      was_stalled = out_valid && !out_ready;
      held_insn = out_insn;
      held_err = out_err;
      if (in_valid && in_ready) begin
        exp_m = model(in_op, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm);
        exp_q.push_back(exp_m);
        if (exp_m[32] && err_exp < (1 << ERRW) - 1) err_exp++;
      end
    end

    // Drain what is left, bounded
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("drain_unexpected_beat", 32'd1, 32'd0);
        end else begin
          head = exp_q.pop_front();
          checkOutput("drain_insn", out_insn, head[31:0]);
          checkOutput("drain_err", 32'(out_err), 32'(head[32]));
        end
      end
      @(negedge clk);
    end
    checkOutput("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("final_err_count", 32'(err_count), 32'(err_exp));

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/ix32_encoder.md
# ix32_encoder

Pipelined RV32IM instruction encoder that packs decoded fields (major opcode, funct3, funct7, register indices, 32-bit immediate) into a 32-bit instruction word in the R/I/S/B/U/J formats, scattering immediate bits as the ISA requires. It is the writer-side counterpart of the instruction decode path. It serves the self-test stimulus generator and the trap/microcode sequencer, which build instructions at run time. The block uses valid/ready on both sides, a one-cycle output register plus a one-entry skid buffer, legality checking, and a saturating error counter.

## Interface
- ERRW, default 16, width of the saturating error counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept; equals !skid_valid (combinational from a flop).
- in_op  in  5  major opcode, genericOpcode encoding (instruction bits [6:2]).
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7; for shift-immediates, imm[11:5].
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  immediate as a signed byte offset/value (U: full 32-bit value).
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts.
- out_insn  out  32  encoded instruction; 0 when out_err=1.
- out_err  out  1  request was illegal.
- err_count  out  ERRW  saturating count of illegal requests accepted.

## Operation
- opcode field is always {in_op, 2'b11}.
- Format by in_op:
  - OP, OP_32: R.
  - OP_IMM, OP_IMM_32, LOAD, JALR, MISC_MEM, SYSTEM: I.
  - STORE: S.
  - BRANCH: B.
  - LUI, AUIPC: U.
  - JAL: J.
- Any other in_op (LOAD_FP, STORE_FP, AMO, OP_FP, MADD..NMADD) is an error.
- Fields a format does not use are ignored, not checked.
- I-type: insn[31:20]=in_imm[11:0]. Shift-immediates (OP_IMM with funct3 001/101) are the exception: insn[31:25]=in_funct7 and insn[24:20]=in_imm[4:0].
- S-type: insn[31:25]=imm[11:5], insn[11:7]=imm[4:0].
- B-type:
  - insn[31]=imm[12], insn[30:25]=imm[10:5].
  - insn[11:8]=imm[4:1], insn[7]=imm[11].
- U-type: insn[31:12]=imm[31:12].
- J-type:
  - insn[31]=imm[20], insn[30:21]=imm[10:1].
  - insn[20]=imm[11], insn[19:12]=imm[19:12].
- Error conditions (any one sets out_err):
  - Immediate range:
    - I/S: in_imm outside signed 12-bit, i.e. [-2048, 2047].
    - Shift-immediate: in_imm outside 0..31.
    - B: in_imm odd or outside [-4096, 4094].
    - J: in_imm odd or outside signed 21-bit.
    - U: in_imm[11:0] ≠ 0.
  - funct3 legality:
    - LOAD: funct3 ∉ {000,001,010,100,101}.
    - STORE: funct3 > 010.
    - BRANCH: funct3 ∈ {010,011}.
    - JALR: funct3 ≠ 000.
  - funct7 legality:
    - OP: funct7 ∉ {0000000, 0100000, 0000001}; also error if funct7=0100000 with funct3 ∉ {000,101}.
    - Shift-immediate: funct7 ∉ {0000000, 0100000}, or 0100000 with funct3=001.
- On error, out_insn=0 and out_err=1. The beat is still delivered in order.
- err_count increments by 1 on each accepted erroneous request and saturates at all-ones.

## Timing
- Reset values:
  - out_valid=0, out_err=0, out_insn=0.
  - skid empty, so in_ready=1.
  - err_count=0.
- Input handshakes while rst=1 are discarded.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Latency: an accepted request appears on out_* the next cycle when the output register is empty or draining. Throughput is 1 per cycle.
- Output register full and out_ready=0 at accept: the encoded beat goes to the skid; in_ready drops next cycle.
- out_ready=1 with skid full: skid moves to the output register, and in_ready rises next cycle. No input is accepted that cycle.
- out_* hold stable while out_valid & !out_ready.
- Ordering is strictly FIFO.
- err_count updates in the cycle after the erroneous request is accepted.
- rst mid-stream: all in-flight beats are dropped and err_count is cleared.

## Test plan
- ADDI x1,x0,5 (OP_IMM, f3=000, rd=1, rs1=0, imm=5) → out_insn=0x00500093, out_err=0, one cycle after accept.
- SRAI x5,x6,3 (f3=101, f7=0100000) → 0x40335293. BEQ x1,x2,-8 → 0xFE208CE3. JAL x1,2048 → 0x001000EF.
- LUI x10 with imm=0x12345000 → 0x12345537. Same request with imm=0x12345001 → out_insn=0, out_err=1, err_count=1.
- BRANCH imm=3 → err. LOAD f3=011 → err. STORE imm=2048 → err. OP_FP → err. err_count=4 after the four requests.
- Backpressure: hold out_ready=0 and offer 3 back-to-back requests. First two are accepted, in_ready=0 on the third, and out_* stay stable. Release out_ready: all three emerge in order, one per cycle.
- Assert rst with both registers full → next cycle out_valid=0, in_ready=1, err_count=0.
